// File: rtl/icache_refill_if.sv
// Instruction-side read bus between the refill engine and the memory interconnect.
interface icache_refill_if;
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic [2:0]  i_arsize;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        i_rvalid;
    logic        i_rready;

    modport master (
        output i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
        input  i_arready, i_rdata, i_rlast, i_rvalid
    );

    modport slave (
        input  i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
        output i_arready, i_rdata, i_rlast, i_rvalid
    );
endinterface

// File: rtl/icache_refill.sv
// I-cache line refill engine: on a miss, issues one incrementing read burst
// for the whole line and assembles the returned beats into refill_line.
module icache_refill #(
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_req,
    input  logic [31:0]             miss_addr,
    output logic                    busy,
    output logic                    refill_done,
    output logic                    refill_err,
    output logic [32*LINE_WORDS-1:0] refill_line,
    icache_refill_if.master         bus
);
    localparam int unsigned CW  = $clog2(LINE_WORDS);
    localparam int unsigned OFF = CW + 2;
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    // Set once the final word slot has been filled without rlast; later beats are dropped.
    logic                    full_q, full_d;
    logic [32*LINE_WORDS-1:0] line_q, line_d;

    // Next-state, beat capture and error tracking.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        full_d  = full_q;
        line_d  = line_q;
        case (state_q)
            S_IDLE: begin
                if (miss_req) begin
                    addr_d  = {miss_addr[31:OFF], {OFF{1'b0}}};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (bus.i_arready) state_d = S_R;
            end
            S_R: begin
                if (bus.i_rvalid) begin
                    if (!full_q) begin
                        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                            if (cnt_q == CW'(i)) line_d[32*i +: 32] = bus.i_rdata;
                        end
                        // cnt saturates at the last slot instead of wrapping.
                        if (cnt_q == LAST) begin
                            if (!bus.i_rlast) begin
                                err_d  = 1'b1;
                                full_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (bus.i_rlast) begin
                        if (cnt_q != LAST) err_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            full_q  <= full_d;
            line_q  <= line_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign refill_done   = (state_q == S_DONE);
    assign refill_err    = (state_q == S_DONE) && err_q;
    assign refill_line   = line_q;
    assign bus.i_arvalid = (state_q == S_AR);
    assign bus.i_araddr  = addr_q;
    assign bus.i_arlen   = 8'(LINE_WORDS - 1);
    assign bus.i_arsize  = 3'b010;
    assign bus.i_rready  = (state_q == S_R);
endmodule

// File: tb/tb_icache_refill.sv
// Directed self-checking bench for icache_refill (LINE_WORDS = 8).
module tb_icache_refill;
    logic         clk;
    logic         rst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         busy;
    logic         refill_done;
    logic         refill_err;
    logic [255:0] refill_line;

    int tests;
    int fails;
    logic [255:0] exp_line;

    icache_refill_if bus ();

    icache_refill #(.LINE_WORDS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .busy        (busy),
        .refill_done (refill_done),
        .refill_err  (refill_err),
        .refill_line (refill_line),
        .bus         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample/drive 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] a, input logic [31:0] exp_a);
        miss_req  = 1'b1;
        miss_addr = a;
        step();
        miss_req  = 1'b0;
        chk("ar_valid", 256'(bus.i_arvalid), 256'(1));
        chk("ar_addr",  256'(bus.i_araddr),  256'(exp_a));
    endtask

    task automatic accept_ar();
        bus.i_arready = 1'b1;
        step();
        bus.i_arready = 1'b0;
    endtask

    task automatic beat(input logic v, input logic [31:0] d, input logic l);
        bus.i_rvalid = v;
        bus.i_rdata  = d;
        bus.i_rlast  = l;
        step();
        bus.i_rvalid = 1'b0;
        bus.i_rlast  = 1'b0;
        bus.i_rdata  = 32'h0;
    endtask

    task automatic full_burst(input logic [31:0] base);
        for (int i = 0; i < 8; i++) beat(1'b1, base + 32'(i), (i == 7));
    endtask

    task automatic check_done(input string tag, input logic e, input logic [255:0] l);
        chk({tag, "_done"}, 256'(refill_done), 256'(1));
        chk({tag, "_err"},  256'(refill_err),  256'(e));
        chk({tag, "_line"}, refill_line, l);
        step();
        chk({tag, "_done_pulse"}, 256'(refill_done), 256'(0));
        chk({tag, "_idle"},       256'(busy),        256'(0));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        miss_req = 1'b0;
        miss_addr = 32'h0;
        bus.i_arready = 1'b0;
        bus.i_rdata = 32'h0;
        bus.i_rlast = 1'b0;
        bus.i_rvalid = 1'b0;
        step();
        step();
        chk("rst_busy",   256'(busy),          256'(0));
        chk("rst_done",   256'(refill_done),   256'(0));
        chk("rst_err",    256'(refill_err),    256'(0));
        chk("rst_arvalid",256'(bus.i_arvalid), 256'(0));
        chk("rst_rready", 256'(bus.i_rready),  256'(0));
        chk("rst_line",   refill_line,         256'(0));
        chk("rst_araddr", 256'(bus.i_araddr),  256'(0));
        rst = 1'b0;
        step();

        // Basic refill, arready on first AR cycle.
        start_miss(32'h1FC0_0014, 32'h1FC0_0000);
        chk("arlen",  256'(bus.i_arlen),  256'(7));
        chk("arsize", 256'(bus.i_arsize), 256'(2));
        chk("busy_ar",256'(busy),         256'(1));
        chk("rready_ar", 256'(bus.i_rready), 256'(0));
        accept_ar();
        chk("arvalid_r", 256'(bus.i_arvalid), 256'(0));
        chk("rready_r",  256'(bus.i_rready),  256'(1));
        full_burst(32'hA0);
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hA0 + 32'(i);
        check_done("basic", 1'b0, exp_line);

        // arready withheld 5 cycles.
        start_miss(32'h0000_1234, 32'h0000_1220);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_arvalid", 256'(bus.i_arvalid), 256'(1));
            chk("stall_araddr",  256'(bus.i_araddr),  256'(32'h0000_1220));
            chk("stall_arlen",   256'(bus.i_arlen),   256'(7));
        end
        accept_ar();
        full_burst(32'hB000_0000);
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hB000_0000 + 32'(i);
        check_done("stall", 1'b0, exp_line);

        // rvalid toggling; idle cycles carry junk data.
        start_miss(32'h0000_2000, 32'h0000_2000);
        accept_ar();
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 32'hC0 + 32'(i), (i == 7));
            if (i != 7) beat(1'b0, 32'hDEAD_BEEF, 1'b1);
        end
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hC0 + 32'(i);
        check_done("toggle", 1'b0, exp_line);

        // Early rlast on 5th beat: words 5..7 keep C5..C7.
        start_miss(32'h0000_3000, 32'h0000_3000);
        accept_ar();
        for (int i = 0; i < 5; i++) beat(1'b1, 32'hD0 + 32'(i), (i == 4));
        for (int i = 0; i < 5; i++) exp_line[32*i +: 32] = 32'hD0 + 32'(i);
        check_done("early", 1'b1, exp_line);

        // Late rlast: extra beats dropped, waits for rlast.
        start_miss(32'h0000_4000, 32'h0000_4000);
        accept_ar();
        for (int i = 0; i < 8; i++) beat(1'b1, 32'hE0 + 32'(i), 1'b0);
        chk("late_still_r", 256'(bus.i_rready), 256'(1));
        beat(1'b1, 32'hF0, 1'b0);
        beat(1'b1, 32'hF1, 1'b0);
        chk("late_no_done", 256'(refill_done), 256'(0));
        beat(1'b1, 32'hF2, 1'b1);
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hE0 + 32'(i);
        check_done("late", 1'b1, exp_line);

        // Reset during 3rd beat.
        start_miss(32'h0000_5000, 32'h0000_5000);
        accept_ar();
        beat(1'b1, 32'h11, 1'b0);
        beat(1'b1, 32'h12, 1'b0);
        rst = 1'b1;
        beat(1'b1, 32'h13, 1'b0);
        rst = 1'b0;
        chk("mid_rst_busy",   256'(busy),          256'(0));
        chk("mid_rst_arvalid",256'(bus.i_arvalid), 256'(0));
        chk("mid_rst_rready", 256'(bus.i_rready),  256'(0));
        chk("mid_rst_line",   refill_line,         256'(0));
        start_miss(32'h0000_6044, 32'h0000_6040);
        accept_ar();
        full_burst(32'h5500);
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h5500 + 32'(i);
        check_done("post_rst", 1'b0, exp_line);

        // miss_req held high: one IDLE cycle between done and next arvalid.
        miss_req  = 1'b1;
        miss_addr = 32'h0000_7000;
        step();
        chk("b2b_arvalid1", 256'(bus.i_arvalid), 256'(1));
        accept_ar();
        full_burst(32'h7700);
        chk("b2b_done", 256'(refill_done), 256'(1));
        chk("b2b_busy_done", 256'(busy), 256'(1));
        step();
        chk("b2b_idle_busy",    256'(busy),          256'(0));
        chk("b2b_idle_arvalid", 256'(bus.i_arvalid), 256'(0));
        step();
        miss_req = 1'b0;
        chk("b2b_arvalid2", 256'(bus.i_arvalid), 256'(1));
        chk("b2b_araddr2",  256'(bus.i_araddr),  256'(32'h0000_7000));
        accept_ar();
        full_burst(32'h8800);
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h8800 + 32'(i);
        check_done("b2b2", 1'b0, exp_line);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
